// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, address type and write-port priority helper for regfile_mp
package regfile_pkg;
  localparam int REG_DEPTH = 5;
  localparam int MAX_PORTS = 8;
  typedef logic [REG_DEPTH-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = '0;
  function automatic int port_sel(input logic [MAX_PORTS-1:0] hit);
    int r;
    r = 0;
    for (int k = 0; k < MAX_PORTS; k++)
      if (hit[k]) r = k;
    return r;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits; ports clk, rst, clr_en/clr_addr per write port, sb_set/sb_addr, busy
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int NWR = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NWR-1:0]         clr_en,
  input  logic [NWR*DEPTH-1:0]   clr_addr,
  input  logic                   sb_set,
  input  logic [DEPTH-1:0]       sb_addr,
  output logic [(1<<DEPTH)-1:0]  busy
);
  logic [(1<<DEPTH)-1:0] nxt;
  // set is applied after clears so a newly issued producer supersedes a retiring one
  always_comb begin
    nxt = busy;
    for (int j = 0; j < NWR; j++)
      if (clr_en[j]) nxt[clr_addr[j*DEPTH +: DEPTH]] = 1'b0;
    if (sb_set && sb_addr != DEPTH'(REG_ZERO)) nxt[sb_addr] = 1'b1;
    nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) busy <= '0;
    else busy <= nxt;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file (r0 = 0) with busy scoreboard; optional write-to-read bypass via REGFILE_BYPASS_EN
// ports: clk, rst (async high); rd_addr/rd_data/rd_busy per read port; wr_en/wr_addr/wr_data per write port;
//        sb_set/sb_addr mark a destination pending; busy is the full scoreboard vector
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5,
  parameter int NRD = 2,
  parameter int NWR = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*DEPTH-1:0]   rd_addr,
  output logic [NRD*WIDTH-1:0]   rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*DEPTH-1:0]   wr_addr,
  input  logic [NWR*WIDTH-1:0]   wr_data,
  input  logic                   sb_set,
  input  logic [DEPTH-1:0]       sb_addr,
  output logic [(1<<DEPTH)-1:0]  busy
);
  logic [WIDTH-1:0] regs [0:(1<<DEPTH)-1];
  // later ports overwrite earlier ones in the loop, so the highest index wins on a collision
  always_ff @(posedge clk or posedge rst)
    if (rst) regs <= '{default: '0};
    else
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*DEPTH +: DEPTH] != DEPTH'(REG_ZERO))
          regs[wr_addr[j*DEPTH +: DEPTH]] <= wr_data[j*WIDTH +: WIDTH];
  regfile_scoreboard #(.DEPTH(DEPTH), .NWR(NWR)) u_sb (
    .clk(clk),
    .rst(rst),
    .clr_en(wr_en),
    .clr_addr(wr_addr),
    .sb_set(sb_set),
    .sb_addr(sb_addr),
    .busy(busy)
  );
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [DEPTH-1:0] a;
    logic [WIDTH-1:0] q;
    assign a = rd_addr[i*DEPTH +: DEPTH];
    assign q = (a == DEPTH'(REG_ZERO)) ? '0 : regs[a];
`ifdef REGFILE_BYPASS_EN
    logic [MAX_PORTS-1:0] hv;
    int s;
    always_comb begin
      hv = '0;
      for (int j = 0; j < NWR; j++)
        hv[j] = wr_en[j] && wr_addr[j*DEPTH +: DEPTH] == a && a != DEPTH'(REG_ZERO);
    end
    assign s = port_sel(hv);
    assign rd_data[i*WIDTH +: WIDTH] = |hv ? wr_data[s*WIDTH +: WIDTH] : q;
    // a retiring write hides the busy bit unless a new producer claims the same register now
    assign rd_busy[i] = |hv ? (sb_set && sb_addr == a) : busy[a];
`else
    assign rd_data[i*WIDTH +: WIDTH] = q;
    assign rd_busy[i] = busy[a];
`endif
  end
endmodule
